// File: rtl/stg_if_pkg.sv
// Shared sizes and types for the instruction-fetch stage.
package stg_if_pkg;

    localparam int SIZE_ADDR   = 32;
    localparam int SIZE_DATA   = 32;
    localparam int FETCH_DEPTH = 4;
    localparam int NOP_INSTR   = 0;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REDIR
    } fetch_state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both for fetched {pc, instr} words and for in-flight PCs.
module fetch_fifo
    import stg_if_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          iw_clk,
    input  logic          iw_rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          clear,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign head    = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge iw_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/stg_if.sv
// Instruction-fetch stage: credit-limited imem reads, response FIFO, stall and redirect handling.
module stg_if
    import stg_if_pkg::*;
#(
    parameter int ADDR_W = SIZE_ADDR,
    parameter int DATA_W = SIZE_DATA,
    parameter int DEPTH  = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    output logic              ow_imem_req,
    output logic [ADDR_W-1:0] ow_imem_addr,
    input  logic              iw_imem_gnt,
    input  logic              iw_imem_rvalid,
    input  logic [DATA_W-1:0] iw_imem_rdata,
    input  logic              iw_redirect,
    input  logic [ADDR_W-1:0] iw_redirect_pc,
    input  logic              iw_stall,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr,
    output logic              ow_valid
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    fetch_state_t             state;
    logic [ADDR_W-1:0]        pc_reg;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            kill_cnt;
    logic [CW-1:0]            kill_next;
    logic [CW:0]              credit_used;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [ADDR_W-1:0]        pcq_head;
    logic [CW-1:0]            pcq_count;
    logic                     pcq_empty;
    logic                     pcq_full;
    logic                     grant;
    logic                     rsp;
    logic                     rsp_keep;
    logic                     pop;

    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign ow_imem_req  = (state == S_RUN) & ~iw_redirect & (credit_used < CREDIT_MAX);
    assign ow_imem_addr = pc_reg;
    assign grant        = ow_imem_req & iw_imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp          = iw_imem_rvalid & (outstanding != '0);
    assign rsp_keep     = rsp & (kill_cnt == '0) & ~iw_redirect;
    assign pop          = ~iw_redirect & ~iw_stall & ~fifo_empty;
    assign kill_next    = outstanding - CW'(rsp);

    fetch_fifo #(.W(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_data_fifo (
        .iw_clk    (iw_clk),
        .iw_rst_n  (iw_rst_n),
        .push      (rsp_keep),
        .push_data ({pcq_head, iw_imem_rdata}),
        .pop       (pop),
        .clear     (iw_redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // PCs of granted reads, popped in order as responses return (including killed ones).
    fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pc_queue (
        .iw_clk    (iw_clk),
        .iw_rst_n  (iw_rst_n),
        .push      (grant),
        .push_data (pc_reg),
        .pop       (rsp),
        .clear     (1'b0),
        .head      (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state       <= S_BOOT;
            pc_reg      <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
            ow_pc       <= '0;
            ow_instr    <= DATA_W'(NOP_INSTR);
            ow_valid    <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(rsp);

            if (iw_redirect) begin
                pc_reg   <= iw_redirect_pc;
                kill_cnt <= kill_next;
                state    <= (kill_next != '0) ? S_REDIR : S_RUN;
            end else begin
                if (grant) pc_reg <= pc_reg + ADDR_W'(1);
                if (rsp && kill_cnt != '0) kill_cnt <= kill_cnt - CW'(1);
                case (state)
                    S_BOOT:  state <= S_RUN;
                    S_REDIR: if (kill_cnt == '0 || (rsp && kill_cnt == CW'(1))) state <= S_RUN;
                    default: state <= state;
                endcase
            end

            if (iw_redirect || (!iw_stall && fifo_empty)) begin
                ow_pc    <= '0;
                ow_instr <= DATA_W'(NOP_INSTR);
                ow_valid <= 1'b0;
            end else if (!iw_stall) begin
                {ow_pc, ow_instr} <= fifo_head;
                ow_valid          <= 1'b1;
            end
        end
    end

    a_rvalid_protocol: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
        !(iw_imem_rvalid && outstanding == '0));
    a_no_fifo_overflow: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
        !(rsp_keep && fifo_full));
    a_pcq_consistent: assert property (@(posedge iw_clk) disable iff (!iw_rst_n)
        !(grant && pcq_full) && !(rsp && pcq_empty) && (pcq_count == outstanding));

endmodule

// File: tb/tb_stg_if.sv
// Randomised and directed bench for stg_if against a transaction-level fetch model.
module tb_stg_if;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              iw_clk = 1'b0;
    logic              iw_rst_n = 1'b0;
    logic              ow_imem_req;
    logic [ADDR_W-1:0] ow_imem_addr;
    logic              iw_imem_gnt = 1'b0;
    logic              iw_imem_rvalid = 1'b0;
    logic [DATA_W-1:0] iw_imem_rdata = '0;
    logic              iw_redirect = 1'b0;
    logic [ADDR_W-1:0] iw_redirect_pc = '0;
    logic              iw_stall = 1'b0;
    logic [ADDR_W-1:0] ow_pc;
    logic [DATA_W-1:0] ow_instr;
    logic              ow_valid;

    stg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .iw_clk         (iw_clk),
        .iw_rst_n       (iw_rst_n),
        .ow_imem_req    (ow_imem_req),
        .ow_imem_addr   (ow_imem_addr),
        .iw_imem_gnt    (iw_imem_gnt),
        .iw_imem_rvalid (iw_imem_rvalid),
        .iw_imem_rdata  (iw_imem_rdata),
        .iw_redirect    (iw_redirect),
        .iw_redirect_pc (iw_redirect_pc),
        .iw_stall       (iw_stall),
        .ow_pc          (ow_pc),
        .ow_instr       (ow_instr),
        .ow_valid       (ow_valid)
    );

    always #5 iw_clk = ~iw_clk;

    // Granted read tagged with the redirect epoch it belongs to.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                epoch;
    } rd_t;

    // Word accepted into the fetch buffer, with the cycle its response arrived.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        int                t;
    } word_t;

    rd_t               mem_q[$];
    word_t             exp_q[$];
    int                epoch = 0;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    int                valid_seen = 0;
    logic [ADDR_W-1:0] pc_model = RESET_PC;
    logic              last_stall = 1'b0;
    logic              last_redir = 1'b0;
    logic [ADDR_W-1:0] exp_pc = '0;
    logic [DATA_W-1:0] exp_instr = '0;
    logic              exp_valid = 1'b0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return 32'h100 + DATA_W'(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic resetModel();
        mem_q.delete();
        exp_q.delete();
        pc_model   = RESET_PC;
        last_stall = 1'b0;
        last_redir = 1'b0;
        exp_pc     = '0;
        exp_instr  = '0;
        exp_valid  = 1'b0;
    endtask

    task automatic quietInputs();
        iw_imem_gnt    = 1'b0;
        iw_imem_rvalid = 1'b0;
        iw_redirect    = 1'b0;
        iw_stall       = 1'b0;
    endtask

    // Reset is held for a few cycles and released on a falling edge; the next edge is the boot cycle.
    task automatic doReset();
        iw_rst_n = 1'b0;
        quietInputs();
        repeat (3) @(negedge iw_clk);
        checkOutput("rst_valid", ow_valid, 0);
        checkOutput("rst_pc", ow_pc, 0);
        checkOutput("rst_instr", ow_instr, 0);
        checkOutput("rst_req", ow_imem_req, 0);
        checkOutput("rst_addr", ow_imem_addr, RESET_PC);
        resetModel();
        iw_rst_n = 1'b1;
    endtask

    task automatic applyStimulus(input logic stall, input logic redir, input logic [ADDR_W-1:0] rpc,
                                 input logic gnt, input logic rsp_en);
        word_t w;
        rd_t   r;
        logic  running;
        logic  do_rsp;
        logic  exp_req;
        @(negedge iw_clk);
        cyc++;
        if (last_redir) begin
            exp_valid = 1'b0; exp_pc = '0; exp_instr = '0;
        end else if (!last_stall) begin
            if (exp_q.size() > 0 && exp_q[0].t <= cyc - 2) begin
                w = exp_q.pop_front();
                exp_valid = 1'b1; exp_pc = w.pc; exp_instr = mem_word(w.pc);
                valid_seen++;
            end else begin
                exp_valid = 1'b0; exp_pc = '0; exp_instr = '0;
            end
        end
        checkOutput("ow_valid", ow_valid, exp_valid);
        checkOutput("ow_pc", ow_pc, exp_pc);
        checkOutput("ow_instr", ow_instr, exp_instr);
        checkOutput("imem_addr", ow_imem_addr, pc_model);

        running = 1'b1;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) running = 1'b0;
        do_rsp  = rsp_en && (mem_q.size() > 0);
        exp_req = running && !redir && (mem_q.size() + exp_q.size() < DEPTH);

        iw_stall       = stall;
        iw_redirect    = redir;
        iw_redirect_pc = rpc;
        iw_imem_gnt    = gnt;
        iw_imem_rvalid = do_rsp;
        iw_imem_rdata  = do_rsp ? mem_word(mem_q[0].addr) : DATA_W'($urandom);
        #1;
        checkOutput("imem_req", ow_imem_req, exp_req);

        if (redir) begin
            epoch++;
            exp_q.delete();
            pc_model = rpc;
        end
        if (do_rsp) begin
            r = mem_q.pop_front();
            if (r.epoch == epoch) exp_q.push_back('{r.addr, cyc});
        end
        if (exp_req && gnt) begin
            mem_q.push_back('{pc_model, epoch});
            pc_model = pc_model + ADDR_W'(1);
        end
        last_stall = stall;
        last_redir = redir;
    endtask

    initial begin
        $display("[TB] reset and streaming");
        doReset();
        repeat (20) applyStimulus(0, 0, '0, 1, 1);
        checkOutput("stream_words", (valid_seen >= 15), 1);

        $display("[TB] stall for 6 cycles");
        repeat (6) applyStimulus(1, 0, '0, 1, 1);
        repeat (10) applyStimulus(0, 0, '0, 1, 1);

        $display("[TB] redirect with reads outstanding");
        repeat (2) applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 1, 8'h40, 1, 0);
        repeat (12) applyStimulus(0, 0, '0, 1, 1);

        $display("[TB] grant withheld for 5 cycles");
        repeat (5) applyStimulus(0, 0, '0, 0, 1);
        repeat (8) applyStimulus(0, 0, '0, 1, 1);

        $display("[TB] address wrap");
        applyStimulus(0, 1, 8'hFE, 1, 1);
        repeat (12) applyStimulus(0, 0, '0, 1, 1);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 25) == 0, ADDR_W'($urandom),
                          ($urandom % 3) != 0, ($urandom % 3) != 0);
        end

        $display("[TB] asynchronous reset mid-transaction");
        repeat (6) applyStimulus(1, 0, '0, 1, ($urandom % 2) == 0);
        #2;
        iw_rst_n = 1'b0;
        #1;
        checkOutput("async_valid", ow_valid, 0);
        checkOutput("async_pc", ow_pc, 0);
        checkOutput("async_instr", ow_instr, 0);
        checkOutput("async_req", ow_imem_req, 0);
        doReset();
        repeat (15) applyStimulus(0, 0, '0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stg_if.md
Name: stg_if

Overview:
Instruction-fetch stage, directly upstream of the decode stage. Keeps the fetch PC and issues word reads to instruction memory over a req/gnt + rvalid interface, with up to DEPTH reads in flight. Buffers returned words in a small FIFO. Presents one {pc, instr} pair per cycle to decode, or a zero bubble when no word is ready. Handles stall from downstream and PC redirect from branch resolution, discarding stale in-flight responses.

Parameters:
ADDR_W, `SIZE_ADDR, PC / memory address width
DATA_W, `SIZE_DATA, instruction word width
DEPTH, 4, FIFO entries; also the cap on outstanding reads plus FIFO occupancy (credit limit, minimum 2)
RESET_PC, 0, PC loaded at reset

Ports:
iw_clk  in  1  clock
iw_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
ow_imem_req  out  1  read request; combinational
ow_imem_addr  out  ADDR_W  read address, equal to pc_reg
iw_imem_gnt  in  1  request accepted this cycle
iw_imem_rvalid  in  1  read data valid; responses return in order
iw_imem_rdata  in  DATA_W  read data
iw_redirect  in  1  branch taken; reload PC
iw_redirect_pc  in  ADDR_W  redirect target
iw_stall  in  1  decode cannot accept; hold outputs
ow_pc  out  ADDR_W  registered PC of the presented instruction
ow_instr  out  DATA_W  registered instruction; 0 means bubble
ow_valid  out  1  registered; ow_instr is a real fetched word

Behaviour:
- Reset (async, iw_rst_n=0):
  - pc_reg=RESET_PC; FIFO empty; outstanding=0; kill_cnt=0; state=S_BOOT.
  - ow_pc=0, ow_instr=0, ow_valid=0; ow_imem_req=0 while in reset.
  - A reset mid-transaction abandons all in-flight reads. Memory is reset together with this block, so no responses arrive afterwards.
- FSM:
  - S_BOOT: one cycle, no request, then go to S_RUN.
  - S_RUN: normal fetch.
  - S_REDIR: discard stale responses; no requests.
- Credit: ow_imem_req = (state==S_RUN) & ~iw_redirect & (outstanding + fifo_count < DEPTH).
- On req & gnt: pc_reg <= pc_reg+1 (word addressed, wraps modulo 2^ADDR_W); push pc_reg onto an internal in-flight PC queue; outstanding +1.
- On rvalid:
  - outstanding -1.
  - If kill_cnt != 0: decrement kill_cnt and drop the word.
  - Otherwise push {queued pc, rdata} into the FIFO.
  - A grant and an rvalid in the same cycle leave outstanding unchanged.
- Output register, updated on each edge when ~iw_stall:
  - If the FIFO is non-empty: pop the head into ow_pc/ow_instr and set ow_valid=1.
  - Otherwise load ow_pc=0, ow_instr=0, ow_valid=0.
  - A word is never pushed and popped in the same cycle (no bypass): rvalid in cycle t makes the word visible at the earliest in cycle t+2.
- Stall:
  - Outputs hold.
  - FIFO keeps filling and requests continue within the credit limit.
  - A full FIFO blocks requests through the credit rule, so no data is ever lost.
- Redirect (cycle t), which overrides stall:
  - At the edge: pc_reg <= iw_redirect_pc; FIFO cleared; output register loaded with a bubble.
  - kill_cnt <= outstanding minus (rvalid in t ? 1 : 0), counting only reads outstanding before t.
  - No request is issued in cycle t.
  - Next state is S_REDIR if the new kill_cnt != 0, else S_RUN.
- S_REDIR: on the edge where kill_cnt reaches 0, go to S_RUN. A second redirect here reloads pc_reg and keeps counting kill_cnt.
- Error: rvalid while outstanding==0 is a protocol error; flag it with a simulation assertion and drop the word.

Decomposition:
- Shared sizes/opcode headers supply ADDR/DATA widths; add FETCH_DEPTH default and a NOP/bubble constant (0).
- One natural sub-module, fetch_fifo: synchronous FIFO of {pc, instr}, DEPTH entries, with push/pop/clear, count, empty/full, async active-low reset.
- The in-flight PC queue reuses fetch_fifo with instr width 0, or is a second instance.

Test Plan:
- Reset release, memory always grants, 1-cycle rvalid, rdata=0x100+addr, no stall -> first ow_valid=1 with pc=0, instr=0x100, then pc 1,2,3… on consecutive cycles (one bubble-free word per cycle after fill).
- iw_stall held 6 cycles mid-stream -> ow_pc/ow_instr frozen; at most DEPTH=4 words buffered; req drops when credit exhausted; after release pcs continue without gaps or duplicates.
- Redirect to 0x40 while 2 reads outstanding -> those 2 responses discarded (kill_cnt 2→0), bubble output, next valid ow_pc=0x40, instr=0x140.
- gnt low for 5 cycles -> ow_valid=0 bubbles (instr=0); pc_reg stays put until granted; sequence resumes in order.
- Async reset asserted while 3 reads outstanding and FIFO holding 2 -> all outputs 0 immediately; after release fetch restarts at RESET_PC.
- pc_reg at 2^ADDR_W-1 -> next fetch address wraps to 0.
